// File: rtl/handshake_slave_fifo.sv
// Valid/ack receive endpoint with a programmable pre-ack wait, buffering accepted words
// in a first-word-fall-through FIFO drained by a valid/ready consumer.
module handshake_slave_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 4,
    parameter bit          FOUR_PHASE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ack,
    input  logic [CNT_W-1:0]             delay_cfg,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         stall
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_REL} state_e;

    state_e              ps_q, ps_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    d_lat_q, d_lat_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0]   fill_q;

    logic                full;
    logic                push;
    logic                pop;

    assign full      = (fill_q == FILL_W'(DEPTH));
    // At most one push is ever in flight, so the not-full check on entry to S_ACK suffices.
    assign push      = (ps_q == S_ACK);
    assign out_valid = (fill_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fill      = fill_q;
    assign in_ack    = (ps_q == S_ACK) || (ps_q == S_REL);

    always_comb begin
        ps_d    = ps_q;
        cnt_d   = cnt_q;
        d_lat_d = d_lat_q;
        stall   = 1'b0;
        unique case (ps_q)
            S_IDLE: begin
                cnt_d = '0;
                if (in_valid) begin
                    d_lat_d = delay_cfg;
                    ps_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!in_valid) begin
                    ps_d  = S_IDLE;
                    cnt_d = '0;
                end else if (cnt_q != d_lat_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (full) begin
                    stall = 1'b1;
                end else begin
                    ps_d = S_ACK;
                end
            end
            S_ACK: begin
                cnt_d = '0;
                ps_d  = FOUR_PHASE ? S_REL : S_IDLE;
            end
            S_REL: begin
                if (!in_valid) ps_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q    <= S_IDLE;
            cnt_q   <= '0;
            d_lat_q <= '0;
        end else begin
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            d_lat_q <= d_lat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_W'(1);
                2'b01:   fill_q <= fill_q - FILL_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Storage is deliberately left uncleared on reset; emptiness is tracked by fill_q.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule
